// File: rtl/l1tlb_l2tlb_req_ctrl_pkg.sv
// Shared types for the L1TLB side of the L1TLB<->L2TLB link.
// Field widths, the page offset and the snoop FSM states.
package l1tlb_l2tlb_req_ctrl_pkg;

    localparam int RID_W    = 2;
    localparam int NUM_RID  = 1 << RID_W;
    localparam int LADDR_W  = 39;
    localparam int SPTBR_W  = 38;
    localparam int HPADDR_W = 11;
    localparam int PPADDR_W = 3;
    localparam int DCTLBE_W = 25;
    localparam int PG_OFF   = 12;

    typedef logic [RID_W-1:0]    rid_t;
    typedef logic [LADDR_W-1:0]  laddr_t;
    typedef logic [SPTBR_W-1:0]  sptbr_t;
    typedef logic [HPADDR_W-1:0] hpaddr_t;
    typedef logic [PPADDR_W-1:0] ppaddr_t;
    typedef logic [DCTLBE_W-1:0] dctlbe_t;

    typedef enum logic [1:0] {
        SN_IDLE = 2'd0,
        SN_INV  = 2'd1,
        SN_SACK = 2'd2
    } snp_st_t;

endpackage

// File: rtl/l1tlb_rid_tracker.sv
// Outstanding-miss tracker: lowest-free allocation, page match,
// and free-on-ack lookup of the stored laddr.
module l1tlb_rid_tracker
    import l1tlb_l2tlb_req_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_alloc,
    input  logic [LADDR_W-1:0] i_alloc_laddr,
    input  logic [LADDR_W-1:0] i_lkup_laddr,
    output logic               o_lkup_hit,
    output logic               o_full,
    output logic [RID_W-1:0]   o_alloc_rid,
    input  logic               i_free,
    input  logic [RID_W-1:0]   i_free_rid,
    output logic               o_free_vld,
    output logic [LADDR_W-1:0] o_free_laddr
);

    logic [NUM_RID-1:0] r_vld;
    laddr_t             r_laddr [NUM_RID];

    always_comb begin
        o_alloc_rid = '0;
        o_lkup_hit  = 1'b0;
        for (int i = NUM_RID - 1; i >= 0; i--) begin
            if (!r_vld[i]) o_alloc_rid = rid_t'(i);
        end
        for (int i = 0; i < NUM_RID; i++) begin
            if (r_vld[i] &&
                r_laddr[i][LADDR_W-1:PG_OFF] ==
                i_lkup_laddr[LADDR_W-1:PG_OFF])
                o_lkup_hit = 1'b1;
        end
    end

    assign o_full       = &r_vld;
    assign o_free_vld   = r_vld[i_free_rid];
    assign o_free_laddr = r_laddr[i_free_rid];

    // Alloc never targets the entry being freed: it only picks free ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            for (int i = 0; i < NUM_RID; i++) r_laddr[i] <= '0;
        end else begin
            if (i_free) r_vld[i_free_rid] <= 1'b0;
            if (i_alloc) begin
                r_vld[o_alloc_rid]   <= 1'b1;
                r_laddr[o_alloc_rid] <= i_alloc_laddr;
            end
        end
    end

endmodule

// File: rtl/l1tlb_l2tlb_req_ctrl.sv
// L1 TLB endpoint of the L1TLB<->L2TLB link: issues miss/disp
// requests, turns acks into fills and services invalidate snoops.
module l1tlb_l2tlb_req_ctrl
    import l1tlb_l2tlb_req_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                miss_valid,
    output logic                miss_retry,
    input  logic [LADDR_W-1:0]  miss_laddr,
    input  logic [SPTBR_W-1:0]  miss_sptbr,
    input  logic                disp_valid,
    output logic                disp_retry,
    input  logic                disp_A,
    input  logic                disp_D,
    input  logic [HPADDR_W-1:0] disp_hpaddr,
    output logic                l1tlbtol2tlb_req_valid,
    input  logic                l1tlbtol2tlb_req_retry,
    output logic [RID_W-1:0]    l1tlbtol2tlb_req_rid,
    output logic                l1tlbtol2tlb_req_disp_req,
    output logic                l1tlbtol2tlb_req_disp_A,
    output logic                l1tlbtol2tlb_req_disp_D,
    output logic [HPADDR_W-1:0] l1tlbtol2tlb_req_disp_hpaddr,
    output logic [LADDR_W-1:0]  l1tlbtol2tlb_req_laddr,
    output logic [SPTBR_W-1:0]  l1tlbtol2tlb_req_sptbr,
    input  logic                l2tlbtol1tlb_ack_valid,
    output logic                l2tlbtol1tlb_ack_retry,
    input  logic [RID_W-1:0]    l2tlbtol1tlb_ack_rid,
    input  logic [HPADDR_W-1:0] l2tlbtol1tlb_ack_hpaddr,
    input  logic [PPADDR_W-1:0] l2tlbtol1tlb_ack_ppaddr,
    input  logic [DCTLBE_W-1:0] l2tlbtol1tlb_ack_dctlbe,
    output logic                fill_valid,
    output logic [LADDR_W-1:0]  fill_laddr,
    output logic [HPADDR_W-1:0] fill_hpaddr,
    output logic [PPADDR_W-1:0] fill_ppaddr,
    output logic [DCTLBE_W-1:0] fill_dctlbe,
    input  logic                l2tlbtol1tlb_snoop_valid,
    output logic                l2tlbtol1tlb_snoop_retry,
    input  logic [RID_W-1:0]    l2tlbtol1tlb_snoop_rid,
    input  logic [HPADDR_W-1:0] l2tlbtol1tlb_snoop_hpaddr,
    output logic                inv_valid,
    output logic [HPADDR_W-1:0] inv_hpaddr,
    output logic                l1tlbtol2tlb_sack_valid,
    input  logic                l1tlbtol2tlb_sack_retry,
    output logic [RID_W-1:0]    l1tlbtol2tlb_sack_rid
);

    logic    w_full, w_hit, w_free_vld, w_ack_hit, w_ack_clash;
    logic    w_req_free, w_disp_acc, w_miss_acc, w_miss_new;
    rid_t    w_alloc_rid;
    laddr_t  w_free_laddr;

    logic    r_req_valid, r_req_disp, r_req_A, r_req_D;
    rid_t    r_req_rid;
    hpaddr_t r_req_hpaddr;
    laddr_t  r_req_laddr;
    sptbr_t  r_req_sptbr;

    logic    r_fill_valid;
    laddr_t  r_fill_laddr;
    hpaddr_t r_fill_hpaddr;
    ppaddr_t r_fill_ppaddr;
    dctlbe_t r_fill_dctlbe;

    snp_st_t r_snp_st;
    rid_t    r_snp_rid;
    hpaddr_t r_snp_hpaddr;

    assign w_req_free = !r_req_valid || !l1tlbtol2tlb_req_retry;
    assign w_disp_acc = disp_valid && w_req_free;
    assign w_miss_acc = miss_valid && !miss_retry;
    assign w_miss_new = w_miss_acc && !w_hit;
    assign disp_retry = !w_req_free;
    assign miss_retry = !w_req_free || w_full || disp_valid;

    l1tlb_rid_tracker u_trk (
        .clk           (clk),
        .reset         (reset),
        .i_alloc       (w_miss_new),
        .i_alloc_laddr (miss_laddr),
        .i_lkup_laddr  (miss_laddr),
        .o_lkup_hit    (w_hit),
        .o_full        (w_full),
        .o_alloc_rid   (w_alloc_rid),
        .i_free        (w_ack_hit),
        .i_free_rid    (l2tlbtol1tlb_ack_rid),
        .o_free_vld    (w_free_vld),
        .o_free_laddr  (w_free_laddr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_valid  <= 1'b0;
            r_req_rid    <= '0;
            r_req_disp   <= 1'b0;
            r_req_A      <= 1'b0;
            r_req_D      <= 1'b0;
            r_req_hpaddr <= '0;
            r_req_laddr  <= '0;
            r_req_sptbr  <= '0;
        end else if (w_disp_acc) begin
            r_req_valid  <= 1'b1;
            r_req_rid    <= '0;
            r_req_disp   <= 1'b1;
            r_req_A      <= disp_A;
            r_req_D      <= disp_D;
            r_req_hpaddr <= disp_hpaddr;
            r_req_laddr  <= '0;
            r_req_sptbr  <= '0;
        end else if (w_miss_new) begin
            r_req_valid  <= 1'b1;
            r_req_rid    <= w_alloc_rid;
            r_req_disp   <= 1'b0;
            r_req_A      <= 1'b0;
            r_req_D      <= 1'b0;
            r_req_hpaddr <= '0;
            r_req_laddr  <= miss_laddr;
            r_req_sptbr  <= miss_sptbr;
        end else if (w_req_free) begin
            r_req_valid  <= 1'b0;
        end
    end

    // A fill racing an invalidate of the same entry is dropped; L1 re-misses.
    assign w_ack_hit   = l2tlbtol1tlb_ack_valid && w_free_vld;
    assign w_ack_clash = (r_snp_st == SN_INV) &&
                         (r_snp_hpaddr == l2tlbtol1tlb_ack_hpaddr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fill_valid  <= 1'b0;
            r_fill_laddr  <= '0;
            r_fill_hpaddr <= '0;
            r_fill_ppaddr <= '0;
            r_fill_dctlbe <= '0;
        end else begin
            r_fill_valid <= w_ack_hit && !w_ack_clash;
            if (w_ack_hit) begin
                r_fill_laddr  <= w_free_laddr;
                r_fill_hpaddr <= l2tlbtol1tlb_ack_hpaddr;
                r_fill_ppaddr <= l2tlbtol1tlb_ack_ppaddr;
                r_fill_dctlbe <= l2tlbtol1tlb_ack_dctlbe;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snp_st     <= SN_IDLE;
            r_snp_rid    <= '0;
            r_snp_hpaddr <= '0;
        end else begin
            unique case (r_snp_st)
                SN_IDLE: if (l2tlbtol1tlb_snoop_valid) begin
                    r_snp_st     <= SN_INV;
                    r_snp_rid    <= l2tlbtol1tlb_snoop_rid;
                    r_snp_hpaddr <= l2tlbtol1tlb_snoop_hpaddr;
                end
                SN_INV:  r_snp_st <= SN_SACK;
                SN_SACK: if (!l1tlbtol2tlb_sack_retry)
                    r_snp_st <= SN_IDLE;
                default: r_snp_st <= SN_IDLE;
            endcase
        end
    end

    assign l1tlbtol2tlb_req_valid       = r_req_valid;
    assign l1tlbtol2tlb_req_rid         = r_req_rid;
    assign l1tlbtol2tlb_req_disp_req    = r_req_disp;
    assign l1tlbtol2tlb_req_disp_A      = r_req_A;
    assign l1tlbtol2tlb_req_disp_D      = r_req_D;
    assign l1tlbtol2tlb_req_disp_hpaddr = r_req_hpaddr;
    assign l1tlbtol2tlb_req_laddr       = r_req_laddr;
    assign l1tlbtol2tlb_req_sptbr       = r_req_sptbr;
    assign l2tlbtol1tlb_ack_retry       = 1'b0;

    assign fill_valid  = r_fill_valid &&
                         !(r_snp_st == SN_INV &&
                           r_snp_hpaddr == r_fill_hpaddr);
    assign fill_laddr  = r_fill_laddr;
    assign fill_hpaddr = r_fill_hpaddr;
    assign fill_ppaddr = r_fill_ppaddr;
    assign fill_dctlbe = r_fill_dctlbe;

    assign l2tlbtol1tlb_snoop_retry = (r_snp_st != SN_IDLE);
    assign inv_valid                = (r_snp_st == SN_INV);
    assign inv_hpaddr               = r_snp_hpaddr;
    assign l1tlbtol2tlb_sack_valid  = (r_snp_st == SN_SACK);
    assign l1tlbtol2tlb_sack_rid    = r_snp_rid;

endmodule

// File: tb/tb_l1tlb_l2tlb_req_ctrl.sv
// Bench for l1tlb_l2tlb_req_ctrl: directed sequences then random
// traffic, all checked against a transaction-level reference model.
module tb_l1tlb_l2tlb_req_ctrl;
    import l1tlb_l2tlb_req_ctrl_pkg::*;

    logic    clk = 1'b0;
    logic    reset = 1'b0;
    always #5 clk = ~clk;

    logic    miss_valid, miss_retry, disp_valid, disp_retry;
    laddr_t  miss_laddr;
    sptbr_t  miss_sptbr;
    logic    disp_A, disp_D;
    hpaddr_t disp_hpaddr;
    logic    req_valid, req_retry, req_disp, req_A, req_D;
    rid_t    req_rid;
    hpaddr_t req_hp;
    laddr_t  req_la;
    sptbr_t  req_sp;
    logic    ack_valid, ack_retry;
    rid_t    ack_rid;
    hpaddr_t ack_hp;
    ppaddr_t ack_pp;
    dctlbe_t ack_de;
    logic    fill_valid;
    laddr_t  fill_la;
    hpaddr_t fill_hp;
    ppaddr_t fill_pp;
    dctlbe_t fill_de;
    logic    snp_valid, snp_retry;
    rid_t    snp_rid;
    hpaddr_t snp_hp;
    logic    inv_valid;
    hpaddr_t inv_hp;
    logic    sack_valid, sack_retry;
    rid_t    sack_rid;

    l1tlb_l2tlb_req_ctrl dut (
        .clk                          (clk),
        .reset                        (reset),
        .miss_valid                   (miss_valid),
        .miss_retry                   (miss_retry),
        .miss_laddr                   (miss_laddr),
        .miss_sptbr                   (miss_sptbr),
        .disp_valid                   (disp_valid),
        .disp_retry                   (disp_retry),
        .disp_A                       (disp_A),
        .disp_D                       (disp_D),
        .disp_hpaddr                  (disp_hpaddr),
        .l1tlbtol2tlb_req_valid       (req_valid),
        .l1tlbtol2tlb_req_retry       (req_retry),
        .l1tlbtol2tlb_req_rid         (req_rid),
        .l1tlbtol2tlb_req_disp_req    (req_disp),
        .l1tlbtol2tlb_req_disp_A      (req_A),
        .l1tlbtol2tlb_req_disp_D      (req_D),
        .l1tlbtol2tlb_req_disp_hpaddr (req_hp),
        .l1tlbtol2tlb_req_laddr       (req_la),
        .l1tlbtol2tlb_req_sptbr       (req_sp),
        .l2tlbtol1tlb_ack_valid       (ack_valid),
        .l2tlbtol1tlb_ack_retry       (ack_retry),
        .l2tlbtol1tlb_ack_rid         (ack_rid),
        .l2tlbtol1tlb_ack_hpaddr      (ack_hp),
        .l2tlbtol1tlb_ack_ppaddr      (ack_pp),
        .l2tlbtol1tlb_ack_dctlbe      (ack_de),
        .fill_valid                   (fill_valid),
        .fill_laddr                   (fill_la),
        .fill_hpaddr                  (fill_hp),
        .fill_ppaddr                  (fill_pp),
        .fill_dctlbe                  (fill_de),
        .l2tlbtol1tlb_snoop_valid     (snp_valid),
        .l2tlbtol1tlb_snoop_retry     (snp_retry),
        .l2tlbtol1tlb_snoop_rid       (snp_rid),
        .l2tlbtol1tlb_snoop_hpaddr    (snp_hp),
        .inv_valid                    (inv_valid),
        .inv_hpaddr                   (inv_hp),
        .l1tlbtol2tlb_sack_valid      (sack_valid),
        .l1tlbtol2tlb_sack_retry      (sack_retry),
        .l1tlbtol2tlb_sack_rid        (sack_rid)
    );

    int n_run = 0;
    int n_fail = 0;

    // Reference model: outstanding table, request slot, pending fill, snoop phase.
    bit      t_v [NUM_RID];
    laddr_t  t_la [NUM_RID];
    bit      q_v, q_disp, q_A, q_D;
    rid_t    q_rid;
    hpaddr_t q_hp;
    laddr_t  q_la;
    sptbr_t  q_sp;
    bit      f_v;
    laddr_t  f_la;
    hpaddr_t f_hp;
    ppaddr_t f_pp;
    dctlbe_t f_de;
    int      s_ph;
    rid_t    s_rid;
    hpaddr_t s_hp;
    bit      p_mret, p_dret, p_sret;

    task automatic check_eq(string tag, logic [63:0] got,
                            logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int n_used();
        int n = 0;
        for (int i = 0; i < NUM_RID; i++) n += int'(t_v[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_RID; i++) begin
            t_v[i] = 0;
            t_la[i] = '0;
        end
        q_v = 0;
        f_v = 0;
        s_ph = 0;
        p_mret = 0;
        p_dret = 0;
        p_sret = 0;
    endtask

    task automatic idle_inputs();
        miss_valid = 0; miss_laddr = '0; miss_sptbr = '0;
        disp_valid = 0; disp_A = 0; disp_D = 0; disp_hpaddr = '0;
        req_retry = 0; ack_valid = 0; ack_rid = '0;
        ack_hp = '0; ack_pp = '0; ack_de = '0;
        snp_valid = 0; snp_rid = '0; snp_hp = '0;
        sack_retry = 0;
    endtask

    task automatic check_zero(string pfx);
        check_eq({pfx, "_req_valid"}, req_valid, 0);
        check_eq({pfx, "_req_rid"}, req_rid, 0);
        check_eq({pfx, "_req_laddr"}, req_la, 0);
        check_eq({pfx, "_fill_valid"}, fill_valid, 0);
        check_eq({pfx, "_fill_laddr"}, fill_la, 0);
        check_eq({pfx, "_inv_valid"}, inv_valid, 0);
        check_eq({pfx, "_inv_hpaddr"}, inv_hp, 0);
        check_eq({pfx, "_sack_valid"}, sack_valid, 0);
        check_eq({pfx, "_sack_rid"}, sack_rid, 0);
    endtask

    task automatic check_outputs();
        bit fr, fe;
        fr = !q_v || !req_retry;
        p_dret = !fr;
        p_mret = !fr || (n_used() == NUM_RID) || disp_valid;
        p_sret = (s_ph != 0);
        check_eq("disp_retry", disp_retry, p_dret);
        check_eq("miss_retry", miss_retry, p_mret);
        check_eq("snoop_retry", snp_retry, p_sret);
        check_eq("ack_retry", ack_retry, 0);
        check_eq("req_valid", req_valid, q_v);
        if (q_v) begin
            check_eq("req_rid", req_rid, q_rid);
            check_eq("req_disp", req_disp, q_disp);
            check_eq("req_A", req_A, q_A);
            check_eq("req_D", req_D, q_D);
            check_eq("req_hpaddr", req_hp, q_hp);
            if (!q_disp) begin
                check_eq("req_laddr", req_la, q_la);
                check_eq("req_sptbr", req_sp, q_sp);
            end
        end
        fe = f_v && !(s_ph == 1 && s_hp == f_hp);
        check_eq("fill_valid", fill_valid, fe);
        if (fe) begin
            check_eq("fill_laddr", fill_la, f_la);
            check_eq("fill_hpaddr", fill_hp, f_hp);
            check_eq("fill_ppaddr", fill_pp, f_pp);
            check_eq("fill_dctlbe", fill_de, f_de);
        end
        check_eq("inv_valid", inv_valid, s_ph == 1);
        if (s_ph == 1) check_eq("inv_hpaddr", inv_hp, s_hp);
        check_eq("sack_valid", sack_valid, s_ph == 2);
        if (s_ph == 2) check_eq("sack_rid", sack_rid, s_rid);
    endtask

    task automatic model_update();
        bit fr, dacc, macc, dup, ahit;
        int fi;
        fr = !q_v || !req_retry;
        dacc = disp_valid && fr;
        macc = miss_valid && fr && !disp_valid &&
               (n_used() < NUM_RID);
        dup = 0;
        fi = -1;
        for (int i = 0; i < NUM_RID; i++)
            if (t_v[i] && t_la[i][LADDR_W-1:PG_OFF] ==
                miss_laddr[LADDR_W-1:PG_OFF]) dup = 1;
        for (int i = NUM_RID - 1; i >= 0; i--)
            if (!t_v[i]) fi = i;
        ahit = ack_valid && t_v[ack_rid];
        if (dacc) begin
            q_v = 1; q_rid = '0; q_disp = 1;
            q_A = disp_A; q_D = disp_D; q_hp = disp_hpaddr;
        end else if (macc && !dup) begin
            q_v = 1; q_rid = rid_t'(fi); q_disp = 0;
            q_A = 0; q_D = 0; q_hp = '0;
            q_la = miss_laddr; q_sp = miss_sptbr;
        end else if (fr) begin
            q_v = 0;
        end
        f_v = ahit && !(s_ph == 1 && s_hp == ack_hp);
        if (ahit) begin
            f_la = t_la[ack_rid];
            f_hp = ack_hp; f_pp = ack_pp; f_de = ack_de;
            t_v[ack_rid] = 0;
        end
        if (macc && !dup) begin
            t_v[fi] = 1;
            t_la[fi] = miss_laddr;
        end
        case (s_ph)
            0: if (snp_valid) begin
                s_ph = 1; s_rid = snp_rid; s_hp = snp_hp;
            end
            1: s_ph = 2;
            default: if (!sack_retry) s_ph = 0;
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_rand();
        if (!(miss_valid && p_mret)) begin
            miss_valid = ($urandom_range(0, 99) < 50);
            miss_laddr = '0;
            miss_laddr[14:12] = 3'($urandom_range(0, 7));
            miss_laddr[11:0] = 12'($urandom);
            miss_sptbr = {6'($urandom), 32'($urandom)};
        end
        if (!(disp_valid && p_dret)) begin
            disp_valid = ($urandom_range(0, 99) < 15);
            disp_A = 1'($urandom);
            disp_D = 1'($urandom);
            disp_hpaddr = 11'($urandom);
        end
        if (!(snp_valid && p_sret)) begin
            snp_valid = ($urandom_range(0, 99) < 20);
            snp_rid = 2'($urandom);
            snp_hp = 11'($urandom_range(0, 3));
        end
        req_retry = ($urandom_range(0, 99) < 35);
        sack_retry = ($urandom_range(0, 99) < 50);
        ack_valid = ($urandom_range(0, 99) < 30);
        ack_rid = 2'($urandom);
        ack_hp = 11'($urandom_range(0, 3));
        ack_pp = 3'($urandom);
        ack_de = 25'($urandom);
    endtask

    task automatic mid_reset();
        reset = 0;
        idle_inputs();
        #1;
        check_zero("mrst");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    initial begin
        bit want_rst;
        want_rst = 0;
        idle_inputs();
        model_reset();
        #2;
        check_zero("rst");
        @(posedge clk);
        #1;
        reset = 1;

        miss_valid = 1; miss_laddr = 39'h1000;
        miss_sptbr = 38'h123;
        cycle();
        miss_valid = 0;
        cycle();
        ack_valid = 1; ack_rid = 0; ack_hp = 11'h5;
        ack_pp = 3'h2; ack_de = 25'h1abc;
        cycle();
        ack_valid = 0;
        cycle();
        cycle();

        miss_valid = 1; miss_laddr = 39'h2000;
        cycle();
        miss_laddr = 39'h2abc;
        cycle();
        miss_laddr = 39'h3000;
        cycle();
        miss_valid = 0;
        disp_valid = 1; disp_A = 1; disp_hpaddr = 11'h7f;
        req_retry = 1;
        cycle();
        disp_valid = 0;
        repeat (3) cycle();
        req_retry = 0;
        cycle();

        snp_valid = 1; snp_rid = 2; snp_hp = 11'h55;
        sack_retry = 1;
        cycle();
        ack_valid = 1; ack_rid = 1; ack_hp = 11'h55;
        cycle();
        ack_valid = 0;
        cycle();
        cycle();
        snp_valid = 0;
        sack_retry = 0;
        cycle();
        cycle();

        for (int i = 0; i < 4000; i++) begin
            if (i % 600 == 599) want_rst = 1;
            if (want_rst && s_ph == 2) begin
                mid_reset();
                want_rst = 0;
            end
            drive_rand();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
